// File: rtl/scene_painter_pkg.sv
// Shared scene encodings, frame constants and painter state for the background path.
package scene_painter_pkg;

  typedef enum logic [1:0] {
    SCENE_START = 2'd0,
    SCENE_GAME  = 2'd1,
    SCENE_END   = 2'd2,
    SCENE_NONE  = 2'd3
  } scene_e;

  localparam int FRAME_W      = 160;
  localparam int FRAME_H      = 120;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } paint_state_e;

  // One slot of the ROM-latency delay line
  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] scene;
  } pix_tag_t;

endpackage

// File: rtl/scene_painter_raster_counter.sv
// Raster-order pixel counter; the linear address runs alongside x/y so no multiply is needed.
module raster_counter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [7:0]        x,
  output logic [7:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              x_wrap_s;

  assign x_wrap_s = (x_q == 8'(WIDTH - 1));

  // Next position: clear wins over advance
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear) begin
      x_d    = 8'd0;
      y_d    = 8'd0;
      addr_d = '0;
    end else if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_wrap_s) begin
        x_d = 8'd0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
        y_d = y_q;
      end
    end else begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= 8'd0;
      y_q    <= 8'd0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;
  assign last = x_wrap_s && (y_q == 8'(HEIGHT - 1));

endmodule

// File: rtl/scene_painter.sv
// Full-screen background painter: sweeps the frame, hides ROM latency, one plot per pixel.
module scene_painter
  import scene_painter_pkg::*;
#(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int ADDR_W      = 15,
  parameter int COLOUR_W    = 12,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          scene_sel,
  input  logic                redraw_req,
  input  logic [COLOUR_W-1:0] start_q,
  input  logic [COLOUR_W-1:0] game_q,
  input  logic [COLOUR_W-1:0] end_q,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [7:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int TAP = ROM_LATENCY - 1;

  paint_state_e state_q, state_d;
  logic [1:0]   cur_scene_q, cur_scene_d;
  logic         pending_q, pending_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;
  logic         request_s;
  logic         cnt_clear_s, cnt_adv_s, cnt_last_s;
  logic [7:0]   cnt_x_s, cnt_y_s;
  pix_tag_t     dl_q [2];
  pix_tag_t     tag_in_s, tap_s;
  logic [COLOUR_W-1:0] colour_s;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (cnt_clear_s),
    .advance (cnt_adv_s),
    .x       (cnt_x_s),
    .y       (cnt_y_s),
    .addr    (rom_addr),
    .last    (cnt_last_s)
  );

  // Scene 3 is a "no change" selection: it neither triggers nor gets latched
  assign request_s = redraw_req || ((scene_sel != SCENE_NONE) && (scene_sel != cur_scene_q));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q || request_s;
    cur_scene_d = cur_scene_q;
    flush_cnt_d = flush_cnt_q;
    cnt_clear_s = 1'b0;
    cnt_adv_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clear_s = 1'b1;
        if (pending_q) begin
          state_d   = ST_FILL;
          pending_d = 1'b0;
          if (scene_sel != SCENE_NONE) begin
            cur_scene_d = scene_sel;
          end else begin
            cur_scene_d = cur_scene_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        flush_cnt_d = 2'd0;
        if (cnt_last_s) begin
          state_d = ST_FLUSH;
        end else begin
          cnt_adv_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 2'(ROM_LATENCY - 1)) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending powers up set so the start scene is painted straight out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cur_scene_q <= 2'd0;
      pending_q   <= 1'b1;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cur_scene_q <= cur_scene_d;
      pending_q   <= pending_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign tag_in_s = '{valid: (state_q == ST_FILL), x: cnt_x_s, y: cnt_y_s, scene: cur_scene_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dl_q[0] <= '0;
      dl_q[1] <= '0;
    end else begin
      dl_q[0] <= tag_in_s;
      dl_q[1] <= dl_q[0];
    end
  end

  assign tap_s = dl_q[TAP];

  always_comb begin
    colour_s = '0;
    if (tap_s.valid) begin
      case (tap_s.scene)
        SCENE_START: colour_s = start_q;
        SCENE_GAME:  colour_s = game_q;
        SCENE_END:   colour_s = end_q;
        default:     colour_s = '0;
      endcase
    end else begin
      colour_s = '0;
    end
  end

  assign colour = colour_s;
  assign x      = tap_s.x;
  assign y      = tap_s.y;
  assign plot   = tap_s.valid;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_scene_painter.sv
// Directed bench: full-size painter (latency 1) and a small-frame painter (latency 2).
module tb_scene_painter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 160x120, latency 1
  logic        rstn_a, redraw_a;
  logic [1:0]  sel_a;
  logic [11:0] sq_a, gq_a, eq_a, colour_a;
  logic [14:0] addr_a;
  logic [7:0]  x_a, y_a;
  logic        plot_a, busy_a, done_a;

  // DUT B: 8x4, latency 2
  logic        rstn_b, redraw_b;
  logic [1:0]  sel_b;
  logic [11:0] sq_b, gq_b, eq_b, colour_b;
  logic [11:0] sr_b, gr_b, er_b;
  logic [4:0]  addr_b;
  logic [7:0]  x_b, y_b;
  logic        plot_b, busy_b, done_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int idx_a = 0, plots_a = 0, bad_a = 0, done_cnt_a = 0, done_cyc_a = -1;
  int first_plot_a = -1, last_plot_a = -1;
  logic [1:0] exp_scene_a = 2'd0;
  int idx_b = 0, plots_b = 0, bad_b = 0, done_cnt_b = 0, done_cyc_b = -1;
  int first_plot_b = -1, last_plot_b = -1;
  logic [1:0] exp_scene_b = 2'd0;

  scene_painter #(.WIDTH(160), .HEIGHT(120), .ADDR_W(15), .COLOUR_W(12), .ROM_LATENCY(1)) dut_a (
    .clk(clk), .resetn(rstn_a), .scene_sel(sel_a), .redraw_req(redraw_a),
    .start_q(sq_a), .game_q(gq_a), .end_q(eq_a), .rom_addr(addr_a),
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  scene_painter #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .COLOUR_W(12), .ROM_LATENCY(2)) dut_b (
    .clk(clk), .resetn(rstn_b), .scene_sel(sel_b), .redraw_req(redraw_b),
    .start_q(sq_b), .game_q(gq_b), .end_q(eq_b), .rom_addr(addr_b),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [11:0] rom_f(input int addr, input logic [1:0] s);
    logic [31:0] a;
    logic [11:0] tag;
    a = addr;
    case (s)
      2'd0:    tag = 12'h111;
      2'd1:    tag = 12'h2c2;
      2'd2:    tag = 12'h4a4;
      default: tag = 12'hfff;
    endcase
    return a[11:0] ^ tag;
  endfunction

  always @(posedge clk) begin
    sq_a <= rom_f(int'(addr_a), 2'd0);
    gq_a <= rom_f(int'(addr_a), 2'd1);
    eq_a <= rom_f(int'(addr_a), 2'd2);
    sr_b <= rom_f(int'(addr_b), 2'd0);
    gr_b <= rom_f(int'(addr_b), 2'd1);
    er_b <= rom_f(int'(addr_b), 2'd2);
    sq_b <= sr_b;
    gq_b <= gr_b;
    eq_b <= er_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge and score both pixel streams
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (plot_a) begin
      if (x_a != 8'(idx_a % 160) || y_a != 8'(idx_a / 160) || colour_a != rom_f(idx_a, exp_scene_a))
        bad_a++;
      if (first_plot_a < 0) first_plot_a = cyc;
      last_plot_a = cyc;
      plots_a++;
      idx_a = (idx_a + 1) % 19200;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (plot_b) begin
      if (x_b != 8'(idx_b % 8) || y_b != 8'(idx_b / 8) || colour_b != rom_f(idx_b, exp_scene_b))
        bad_b++;
      if (first_plot_b < 0) first_plot_b = cyc;
      last_plot_b = cyc;
      plots_b++;
      idx_b = (idx_b + 1) % 32;
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  endtask

  task automatic wait_done_b(input string tag, input int n);
    int k = 0;
    while (done_cnt_b < n && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(done_cnt_b), 32'(n));
  endtask

  initial begin
    int busy_seen;
    rstn_a = 1'b0; rstn_b = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0;
    redraw_a = 1'b0; redraw_b = 1'b0;
    repeat (3) @(negedge clk);

    chk("a_rst_addr",   32'(addr_a), 32'd0);
    chk("a_rst_xy",     32'({x_a, y_a}), 32'd0);
    chk("a_rst_colour", 32'(colour_a), 32'd0);
    chk("a_rst_flags",  32'({plot_a, busy_a, done_a}), 32'd0);

    // ---- Phase A: reset frame, scene switch to game at pixel 5000 ----
    rstn_a = 1'b1;
    cyc = 0;
    while (done_cnt_a == 0 && cyc < 19400) begin
      tick();
      if (plots_a == 5000) sel_a = 2'd1;
      if (cyc == 1) begin
        chk("a_c1_busy", 32'(busy_a), 32'd1);
        chk("a_c1_addr", 32'(addr_a), 32'd0);
        chk("a_c1_plot", 32'(plot_a), 32'd0);
      end
      if (cyc == 2) begin
        chk("a_first_xy",     32'({x_a, y_a}), 32'd0);
        chk("a_first_colour", 32'(colour_a), 32'(rom_f(0, 2'd0)));
      end
      if (cyc == 19201) begin
        chk("a_last_plot",   32'(plot_a), 32'd1);
        chk("a_last_xy",     32'({x_a, y_a}), 32'({8'd159, 8'd119}));
        chk("a_last_colour", 32'(colour_a), 32'(rom_f(19199, 2'd0)));
      end
    end
    chk("a_f1_done_seen",  32'(done_cnt_a), 32'd1);
    chk("a_f1_done_cyc",   32'(done_cyc_a), 32'd19202);
    chk("a_f1_first_plot", 32'(first_plot_a), 32'd2);
    chk("a_f1_last_plot",  32'(last_plot_a), 32'd19201);
    chk("a_f1_plots",      32'(plots_a), 32'd19200);
    chk("a_f1_pix_bad",    32'(bad_a), 32'd0);

    exp_scene_a = 2'd1;
    tick();
    chk("a_gap_busy", 32'(busy_a), 32'd0);
    chk("a_gap_done", 32'(done_a), 32'd0);
    tick();
    chk("a_f2_busy", 32'(busy_a), 32'd1);
    chk("a_f2_addr", 32'(addr_a), 32'd0);
    first_plot_a = -1;
    while (done_cnt_a < 2 && cyc < 38600) tick();
    chk("a_f2_done_seen",  32'(done_cnt_a), 32'd2);
    chk("a_f2_done_cyc",   32'(done_cyc_a), 32'd38405);
    chk("a_f2_first_plot", 32'(first_plot_a), 32'd19205);
    chk("a_f2_plots",      32'(plots_a), 32'd38400);
    chk("a_f2_pix_bad",    32'(bad_a), 32'd0);
    rstn_a = 1'b0;

    // ---- Phase B: latency 2, redraw coalescing, scene 3, async reset ----
    rstn_b = 1'b1;
    cyc = 0;
    while (done_cnt_b < 2 && cyc < 300) begin
      tick();
      redraw_b = (plots_b == 5 || plots_b == 10 || plots_b == 15);
      if (cyc == 1) chk("b_c1_addr", 32'(addr_b), 32'd0);
      if (cyc == 2) chk("b_c2_plot", 32'(plot_b), 32'd0);
      if (cyc == 3) chk("b_c3_plot", 32'(plot_b), 32'd1);
      if (cyc == 34) chk("b_last_xy", 32'({x_b, y_b}), 32'({8'd7, 8'd3}));
      if (cyc == 35) chk("b_f1_done_cyc", 32'(done_cyc_b), 32'd35);
    end
    redraw_b = 1'b0;
    chk("b_coalesce_done", 32'(done_cnt_b), 32'd2);
    chk("b_f2_done_cyc",   32'(done_cyc_b), 32'd71);
    repeat (3) tick();
    chk("b_no_third_busy", 32'(busy_b), 32'd0);
    chk("b_coalesce_plots", 32'(plots_b), 32'd64);
    chk("b_coalesce_bad",   32'(bad_b), 32'd0);

    sel_b = 2'd2;
    exp_scene_b = 2'd2;
    wait_done_b("b_end_done", 3);
    chk("b_end_plots", 32'(plots_b), 32'd96);

    sel_b = 2'd3;
    busy_seen = 0;
    repeat (20) begin
      tick();
      if (busy_b) busy_seen = 1;
    end
    chk("b_sel3_busy",  32'(busy_seen), 32'd0);
    chk("b_sel3_plots", 32'(plots_b), 32'd96);

    redraw_b = 1'b1;
    tick();
    redraw_b = 1'b0;
    wait_done_b("b_sel3_redraw_done", 4);
    chk("b_sel3_redraw_plots", 32'(plots_b), 32'd128);
    chk("b_sel3_redraw_bad",   32'(bad_b), 32'd0);

    sel_b = 2'd1;
    exp_scene_b = 2'd1;
    begin
      int k = 0;
      while (plots_b < 138 && k < 200) begin
        tick();
        k++;
      end
    end
    chk("b_mid_plot", 32'(plot_b), 32'd1);
    #2 rstn_b = 1'b0;
    #1;
    chk("b_async_plot", 32'(plot_b), 32'd0);
    chk("b_async_busy", 32'(busy_b), 32'd0);
    sel_b = 2'd0;
    exp_scene_b = 2'd0;
    idx_b = 0;
    repeat (2) tick();
    chk("b_rst_plots", 32'(plots_b), 32'd138);
    rstn_b = 1'b1;
    cyc = 0;
    tick();
    chk("b_rel_busy", 32'(busy_b), 32'd1);
    chk("b_rel_addr", 32'(addr_b), 32'd0);
    wait_done_b("b_rel_done", 5);
    chk("b_rel_done_cyc", 32'(done_cyc_b), 32'd35);
    chk("b_rel_plots",    32'(plots_b), 32'd170);
    chk("b_pix_bad",      32'(bad_b), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
